// File: rtl/frame_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_ctrl_if
// Brief    : Frame-buffer read port plus Avalon-ST source bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_stream_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic              src_ready;
  logic              src_valid;
  logic [29:0]       src_data;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output rd_addr,
    input  rd_data,
    input  src_ready,
    output src_valid,
    output src_data,
    output src_sop,
    output src_eop
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    output src_ready,
    input  src_valid,
    input  src_data,
    input  src_sop,
    input  src_eop
  );
endinterface
`default_nettype wire

// File: rtl/frame_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_ctrl
// Brief    : Raster-order frame buffer reader feeding an Avalon-ST source
//            through a 2-entry skid FIFO, RGB444 expanded to 30-bit RGB.
// Revision : 1.0 - initial release
// ============================================================================
module frame_stream_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 resync,
  frame_stream_ctrl_if.master       bus,
  output      logic                 frame_done,
  output      logic [CNT_W-1:0]     frame_count
);

  localparam int                c_PIXELS = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] c_LAST   = ADDR_W'(c_PIXELS - 1);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_inflight;
  logic              r_inflight_sop;
  logic              r_inflight_eop;
  logic [31:0]       r_fifo [2];
  logic              r_wr_idx;
  logic              r_rd_idx;
  logic [1:0]        r_count;
  logic              r_frame_done;
  logic [CNT_W-1:0]  r_frame_count;

  logic [31:0]       w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic [29:0]       w_expanded;

  always_comb begin
    w_head     = r_fifo[r_rd_idx];
    w_valid    = (r_count != 2'd0);
    w_pop      = w_valid & bus.src_ready;
    w_push     = r_inflight;
    // Slots committed after this cycle's pop; a new read needs one left free.
    w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue    = (w_occ < 3'd2);
    w_expanded = {bus.rd_data[11:8], bus.rd_data[11:8], 2'b00,
                  bus.rd_data[7:4],  bus.rd_data[7:4],  2'b00,
                  bus.rd_data[3:0],  bus.rd_data[3:0],  2'b00};
  end

  assign bus.rd_addr   = r_ptr;
  assign bus.src_valid = w_valid;
  assign bus.src_data  = w_head[29:0];
  assign bus.src_sop   = w_valid & w_head[31];
  assign bus.src_eop   = w_valid & w_head[30];
  assign frame_done    = r_frame_done;
  assign frame_count   = r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr          <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
      r_wr_idx       <= 1'b0;
      r_rd_idx       <= 1'b0;
      r_count        <= 2'd0;
      r_frame_done   <= 1'b0;
      r_frame_count  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (resync) begin
        r_ptr      <= '0;
        r_inflight <= 1'b0;
        r_wr_idx   <= 1'b0;
        r_rd_idx   <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        if (w_issue) begin
          r_ptr          <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
          r_inflight_sop <= (r_ptr == '0);
          r_inflight_eop <= (r_ptr == c_LAST);
        end
        r_inflight <= w_issue;
        if (w_push) begin
          r_fifo[r_wr_idx] <= {r_inflight_sop, r_inflight_eop, w_expanded};
          r_wr_idx         <= ~r_wr_idx;
        end
        if (w_pop) begin
          r_rd_idx <= ~r_rd_idx;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
      // An accepted beat stays accepted even if resync lands in the same cycle.
      r_frame_done <= w_pop & w_head[30];
      if (w_pop & w_head[30]) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
